request_unit: RTL and testbench
===============================

# request_unit

Sequencer between the control unit and the instruction/data caches on the single-cycle datapath. It issues instruction fetches, then turns the control unit's decoded memory intent (dREN/dWEN/datomic/halt) into cache requests. It holds those requests until the cache acknowledges with ihit/dhit, and produces the PC-advance enable. It also owns the LL/SC link register and the sticky halt.

## Interface
Parameters
- ADDR_W, 32, byte-address width (matches word_t)

Ports
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- cu_dREN  in  1  decoded load (from control unit, valid while ihit)
- cu_dWEN  in  1  decoded store
- cu_datomic  in  1  decoded LL (with dREN) / SC (with dWEN)
- cu_halt  in  1  decoded HALT
- cu_dmemaddr  in  32  effective address (ALU port_o)
- cu_dmemstore  in  32  store data (rdat2)
- ihit  in  1  icache hit; imemload valid
- dhit  in  1  dcache done
- dmemload  in  32  dcache read data
- iREN  out  1  instruction read request
- dREN  out  1  data read request
- dWEN  out  1  data write request
- dmemaddr  out  32  latched data address
- dmemstore  out  32  latched store data
- halt  out  1  sticky halt to caches/system
- pc_en  out  1  advance PC this cycle
- rdata  out  32  registered load data
- sc_valid  out  1  one-cycle pulse: SC resolved
- sc_result  out  1  1 = SC succeeded, 0 = failed (valid with sc_valid)

## Operation
- FSM states: FETCH, MEM, HALTED.
- Reset values: state FETCH, iREN 1; dREN, dWEN, halt, pc_en and sc_valid 0; sc_result 0; rdata, dmemaddr and dmemstore 0; link_valid 0, link_addr 0.
- FETCH: iREN=1, dREN=dWEN=0. Ignore dhit. On ihit:
  - cu_halt=1 → HALTED, pc_en=0.
  - SC (cu_dWEN & cu_datomic) with !(link_valid & link_addr==cu_dmemaddr) → stay FETCH, no memory access, pc_en=1, sc_valid=1, sc_result=0.
  - Otherwise cu_dREN|cu_dWEN → MEM. Latch addr, store data, op and atomic flag. pc_en=0.
  - Otherwise pc_en=1, stay FETCH.
  - cu_dREN and cu_dWEN both set is illegal; dREN takes priority.
- MEM: iREN=0; dREN/dWEN driven from latched op. Ignore ihit. On dhit:
  - pc_en=1, → FETCH.
  - Load: rdata ← dmemload.
  - LL: additionally link_valid←1, link_addr←dmemaddr.
  - SC: sc_valid=1, sc_result=1.
  - Any completed write (SW or SC) with dmemaddr==link_addr clears link_valid.
- HALTED: halt=1. iREN, dREN, dWEN and pc_en are 0. Stays HALTED until RST; hits are ignored.
- Address compare is full 32-bit word address; bits[1:0] are ignored.

## Timing
- iREN, dREN, dWEN and halt are Moore outputs, decoded from the registered state and latches.
- pc_en, sc_valid and sc_result are Mealy, asserted in the same cycle as the qualifying hit.
- rdata and link state update on the CLK edge ending the dhit cycle.
- Minimum instruction: 1 cycle (ihit in the first FETCH cycle).
- Minimum memory instruction: 2 cycles (ihit, then dhit).
- Requests stay asserted and stable until their hit; there is no timeout.
- RST mid-MEM: the next cycle is FETCH with dREN/dWEN=0. The pending access is abandoned and the link is cleared.
- RST has priority over every hit in the same cycle.

## Structure
- Add `ru_state_t` (FETCH, MEM, HALTED) to cpu_types_pkg, next to pcselect_t and wdatselect_t.
- Add `request_unit_if` (modports ru, tb) under include/, matching control_unit_if.
- Single module; optional sub-module `link_reg` holding link_valid/link_addr with set/clear/match ports.

## Test plan
- Reset then ihit with no memory op: pc_en=1 in that cycle, state stays FETCH, iREN=1, dREN=dWEN=0.
- LW at 0x100: ihit → dREN=1 next cycle. Three stall cycles, then dhit with dmemload=0xDEADBEEF → pc_en=1, rdata=0xDEADBEEF, iREN=1 on the following cycle.
- LL 0x200 then SC 0x200: sc_valid=1, sc_result=1, dWEN asserted until dhit. A second SC 0x200 fails without dWEN: sc_result=0, pc_en=1.
- LL 0x200, SW 0x200, SC 0x200 → SC fails. LL 0x200, SW 0x204, SC 0x200 → SC succeeds.
- HALT decoded at ihit: halt=1 from the next cycle, iREN=0, pc_en=0. Later ihit/dhit pulses cause no change; RST returns to FETCH with halt=0.
- RST asserted mid-MEM with dWEN=1 and dhit arriving the same cycle → no pc_en, dWEN=0 and link_valid=0 next cycle.

Source files
------------

// File: rtl/request_unit_pkg.sv
// Shared types for the request unit: sequencer state and word-address helpers.
package request_unit_pkg;
  typedef enum logic [1:0] {FETCH, MEM, HALTED} ru_state_t;

  // Byte offset bits dropped when comparing word addresses.
  localparam int WORD_LSB = 2;
endpackage

// File: rtl/request_unit_link_reg.sv
// LL/SC link register: remembers the word address of the last LL and
// reports whether a given address falls on that same word.
module link_reg
  import request_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              match
);
  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= set_addr;
    end else if (clr) begin
      link_valid <= 1'b0;
    end
  end

  assign match = link_valid &&
                 (link_addr[ADDR_W-1:WORD_LSB] == cmp_addr[ADDR_W-1:WORD_LSB]);
endmodule

// File: rtl/request_unit.sv
// Request sequencer between control unit and caches: fetch, hold one data
// access until dhit, gate PC advance, resolve LL/SC, and latch HALT.
module request_unit
  import request_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cu_dREN,
  input  logic              cu_dWEN,
  input  logic              cu_datomic,
  input  logic              cu_halt,
  input  logic [ADDR_W-1:0] cu_dmemaddr,
  input  logic [31:0]       cu_dmemstore,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [31:0]       dmemload,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [31:0]       dmemstore,
  output logic              halt,
  output logic              pc_en,
  output logic [31:0]       rdata,
  output logic              sc_valid,
  output logic              sc_result
);
  ru_state_t         state, next;
  logic              op_rd, op_wr, op_atomic;
  logic              latch_en, load_en, link_set, link_clr, match, is_sc;
  logic [ADDR_W-1:0] cmp_addr;

  // Both enables set decodes as a load.
  assign is_sc = cu_dWEN && !cu_dREN && cu_datomic;

  link_reg #(.ADDR_W(ADDR_W)) u_link (
    .clk      (CLK),
    .rst      (RST),
    .set      (link_set),
    .clr      (link_clr),
    .set_addr (dmemaddr),
    .cmp_addr (cmp_addr),
    .match    (match)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      op_rd     <= 1'b0;
      op_wr     <= 1'b0;
      op_atomic <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      rdata     <= '0;
    end else begin
      state <= next;
      if (latch_en) begin
        op_rd     <= cu_dREN;
        op_wr     <= cu_dWEN && !cu_dREN;
        op_atomic <= cu_datomic;
        dmemaddr  <= cu_dmemaddr;
        dmemstore <= cu_dmemstore;
      end
      if (load_en) rdata <= dmemload;
    end
  end

  // Hits are qualified with !RST so a same-cycle reset suppresses every pulse.
  always_comb begin
    next      = state;
    pc_en     = 1'b0;
    sc_valid  = 1'b0;
    sc_result = 1'b0;
    latch_en  = 1'b0;
    load_en   = 1'b0;
    link_set  = 1'b0;
    link_clr  = 1'b0;
    cmp_addr  = cu_dmemaddr;
    unique case (state)
      FETCH: begin
        if (ihit && !RST) begin
          if (cu_halt) begin
            next = HALTED;
          end else if (is_sc && !match) begin
            pc_en    = 1'b1;
            sc_valid = 1'b1;
          end else if (cu_dREN || cu_dWEN) begin
            next     = MEM;
            latch_en = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      MEM: begin
        cmp_addr = dmemaddr;
        if (dhit && !RST) begin
          next  = FETCH;
          pc_en = 1'b1;
          if (op_rd) begin
            load_en  = 1'b1;
            link_set = op_atomic;
          end else begin
            sc_valid  = op_atomic;
            sc_result = op_atomic;
            link_clr  = match;
          end
        end
      end
      HALTED: ;
      default: next = FETCH;
    endcase
  end

  assign iREN = (state == FETCH);
  assign dREN = (state == MEM) && op_rd;
  assign dWEN = (state == MEM) && op_wr;
  assign halt = (state == HALTED);
endmodule

// File: tb/tb_request_unit.sv
// Directed and randomized checks of request_unit against a transaction-level
// model of fetch / pending access / link / halt.
module tb_request_unit;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        cu_dREN = 0, cu_dWEN = 0, cu_datomic = 0, cu_halt = 0;
  logic [31:0] cu_dmemaddr = 0, cu_dmemstore = 0, dmemload = 0;
  logic        ihit = 0, dhit = 0;
  logic        iREN, dREN, dWEN, halt, pc_en, sc_valid, sc_result;
  logic [31:0] dmemaddr, dmemstore, rdata;

  int total = 0, bad = 0;

  request_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_datomic(cu_datomic),
    .cu_halt(cu_halt), .cu_dmemaddr(cu_dmemaddr), .cu_dmemstore(cu_dmemstore),
    .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .pc_en(pc_en), .rdata(rdata),
    .sc_valid(sc_valid), .sc_result(sc_result)
  );

  always #5 CLK = ~CLK;

  // Model: is an instruction halted, is a data access outstanding, what is linked.
  bit          m_halted, m_pend, m_rd, m_wr, m_at, m_lv;
  logic [31:0] m_addr, m_store, m_rdata, m_la;

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_pend = 0; m_rd = 0; m_wr = 0; m_at = 0; m_lv = 0;
    m_addr = 0; m_store = 0; m_rdata = 0; m_la = 0;
  endtask

  task automatic step(input bit r, input bit ih, input bit dh, input bit rd,
                      input bit wr, input bit at, input bit hl,
                      input logic [31:0] a, input logic [31:0] st, input logic [31:0] ld);
    bit e_pc, e_scv, e_scr, is_sc, sc_fail;
    @(negedge CLK);
    RST = r; ihit = ih; dhit = dh; cu_dREN = rd; cu_dWEN = wr; cu_datomic = at;
    cu_halt = hl; cu_dmemaddr = a; cu_dmemstore = st; dmemload = ld;
    #1;
    is_sc   = wr && !rd && at;
    sc_fail = is_sc && !(m_lv && same_word(m_la, a));
    e_pc = 0; e_scv = 0; e_scr = 0;
    if (!r && !m_halted) begin
      if (m_pend) begin
        if (dh) begin e_pc = 1; e_scv = m_wr && m_at; e_scr = e_scv; end
      end else if (ih && !hl) begin
        if (sc_fail) begin e_pc = 1; e_scv = 1; end
        else if (!(rd || wr)) e_pc = 1;
      end
    end
    check("iREN", iREN, !m_halted && !m_pend);
    check("dREN", dREN, m_pend && m_rd);
    check("dWEN", dWEN, m_pend && m_wr);
    check("halt", halt, m_halted);
    check("pc_en", pc_en, e_pc);
    check("sc_valid", sc_valid, e_scv);
    check("sc_result", sc_result, e_scr);
    check("rdata", rdata, m_rdata);
    check("dmemaddr", dmemaddr, m_addr);
    check("dmemstore", dmemstore, m_store);
    if (r) model_reset();
    else if (m_halted) ;
    else if (m_pend) begin
      if (dh) begin
        m_pend = 0;
        if (m_rd) begin
          m_rdata = ld;
          if (m_at) begin m_lv = 1; m_la = m_addr; end
        end else if (m_lv && same_word(m_la, m_addr)) m_lv = 0;
      end
    end else if (ih) begin
      if (hl) m_halted = 1;
      else if (!sc_fail && (rd || wr)) begin
        m_pend = 1; m_rd = rd; m_wr = wr && !rd; m_at = at;
        m_addr = a; m_store = st;
      end
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // One memory instruction: ihit with the decoded op, then dhit.
  task automatic mem_op(input bit rd, input bit wr, input bit at,
                        input logic [31:0] a, input logic [31:0] st, input logic [31:0] ld);
    step(0, 1, 0, rd, wr, at, 0, a, st, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, ld);
  endtask

  logic [31:0] addrs [4] = '{32'h200, 32'h204, 32'h202, 32'h300};

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Plain ihit: single-cycle instruction.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // LW 0x100 with three stall cycles.
    step(0, 1, 0, 1, 0, 0, 0, 32'h100, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    idle();
    check("lw_rdata_const", rdata, 32'hDEADBEEF);
    // LL/SC success, then a repeat SC fails without a write.
    mem_op(1, 0, 1, 32'h200, 0, 32'h11);
    step(0, 1, 0, 0, 1, 1, 0, 32'h200, 32'h55, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 32'h200, 32'h66, 0);
    // Intervening SW to the same word kills the link; to another word does not.
    mem_op(1, 0, 1, 32'h200, 0, 1);
    mem_op(0, 1, 0, 32'h200, 7, 0);
    step(0, 1, 0, 0, 1, 1, 0, 32'h200, 8, 0);
    mem_op(1, 0, 1, 32'h200, 0, 2);
    mem_op(0, 1, 0, 32'h204, 7, 0);
    mem_op(0, 1, 1, 32'h201, 9, 0);
    // Reset mid-SC with dhit in the same cycle drops access and link.
    mem_op(1, 0, 1, 32'h200, 0, 3);
    step(0, 1, 0, 0, 1, 1, 0, 32'h200, 4, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 32'h200, 4, 0);
    // Halt is sticky until reset.
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 32'h40, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 32'h40, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Randomized traffic over a few colliding addresses.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(63) == 0) || (m_halted && $urandom_range(7) == 0);
      step(r, $urandom_range(1), $urandom_range(1), $urandom_range(1),
           $urandom_range(1), $urandom_range(1), $urandom_range(39) == 0,
           addrs[$urandom_range(3)] | $urandom_range(3), $urandom, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
